// File: rtl/dsd_mc_decim.sv
// Multi-channel decimating FIR: per-channel circular sample history, one serial
// MAC pass per DECIM accepted samples of a channel, rounded and saturated output.
module dsd_mc_decim #(
  parameter int          AUDIO_WIDTH    = 24,
  parameter int          COEFF_W        = 16,
  parameter int          NCOEFFS        = 64,
  parameter int          DECIM          = 4,
  parameter int          NCHAN          = 2,
  parameter int          OUT_SHIFT      = 15,
  parameter bit          FIXED_COEFFS   = 1'b0,
  parameter string       INITIAL_COEFFS = "",
  localparam int         LGN_COEFFS     = $clog2(NCOEFFS),
  localparam int         LGCH           = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_cwr,
  input  logic [LGN_COEFFS-1:0]         i_caddr,
  input  logic [COEFF_W-1:0]            i_cdata,
  output logic                          o_cbusy,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [LGCH-1:0]               i_chan,
  input  logic signed [AUDIO_WIDTH-1:0] i_sample,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [LGCH-1:0]               o_chan,
  output logic signed [AUDIO_WIDTH-1:0] o_sample
);

  localparam int ACC_W  = AUDIO_WIDTH + COEFF_W + LGN_COEFFS;
  localparam int PROD_W = AUDIO_WIDTH + COEFF_W;
  localparam int FILL_W = LGN_COEFFS + 1;
  localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic signed [ACC_W:0] ONE     = (ACC_W+1)'(1);
  localparam logic signed [ACC_W:0] RND     = (ONE << OUT_SHIFT) >> 1;
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W-AUDIO_WIDTH+2){1'b0}}, {(AUDIO_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_OUT} state_t;

  logic signed [AUDIO_WIDTH-1:0] dmem [NCHAN][NCOEFFS];
  logic signed [COEFF_W-1:0]     cmem [NCOEFFS];

  state_t                        state_q, state_d;
  logic [LGN_COEFFS-1:0]         wptr_q  [NCHAN];
  logic [LGN_COEFFS-1:0]         wptr_d  [NCHAN];
  logic [PH_W-1:0]               phase_q [NCHAN];
  logic [PH_W-1:0]               phase_d [NCHAN];
  logic [FILL_W-1:0]             fill_q  [NCHAN];
  logic [FILL_W-1:0]             fill_d  [NCHAN];
  logic [LGCH-1:0]               chan_q, chan_d;
  logic [LGN_COEFFS-1:0]         tap_q, tap_d;
  logic [LGN_COEFFS-1:0]         rptr_q, rptr_d;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic                          o_valid_q, o_valid_d;
  logic [LGCH-1:0]               o_chan_q, o_chan_d;
  logic signed [AUDIO_WIDTH-1:0] o_sample_q, o_sample_d;

  logic                          idle, chan_ok, dmem_we, cmem_we;
  logic signed [PROD_W-1:0]      prod;
  logic signed [ACC_W:0]         acc_rnd, y;
  logic signed [AUDIO_WIDTH-1:0] y_sat;

  assign idle    = (state_q == S_IDLE);
  assign chan_ok = ({1'b0, i_chan} < (LGCH+1)'(NCHAN));
  assign dmem_we = i_valid && idle && chan_ok;
  assign cmem_we = i_cwr && idle && !FIXED_COEFFS;

  // Both operands are signed, so the product is full-precision two's complement.
  assign prod    = cmem[tap_q] * dmem[chan_q][rptr_q];

  assign acc_rnd = {acc_q[ACC_W-1], acc_q} + RND;
  assign y       = acc_rnd >>> OUT_SHIFT;

  always_comb begin
    y_sat = y[AUDIO_WIDTH-1:0];
    if (y > SAT_MAX)      y_sat = SAT_MAX[AUDIO_WIDTH-1:0];
    else if (y < SAT_MIN) y_sat = SAT_MIN[AUDIO_WIDTH-1:0];
  end

  // NOTE: every variable gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    phase_d    = phase_q;
    fill_d     = fill_q;
    chan_d     = chan_q;
    tap_d      = tap_q;
    rptr_d     = rptr_q;
    acc_d      = acc_q;
    o_valid_d  = o_valid_q;
    o_chan_d   = o_chan_q;
    o_sample_d = o_sample_q;

    unique case (state_q)
      S_IDLE: begin
        if (dmem_we) begin
          wptr_d[i_chan] = (wptr_q[i_chan] == LGN_COEFFS'(NCOEFFS-1)) ? '0
                                                                     : wptr_q[i_chan] + 1'b1;
          if (fill_q[i_chan] != FILL_W'(NCOEFFS)) fill_d[i_chan] = fill_q[i_chan] + 1'b1;
          if (phase_q[i_chan] == PH_W'(DECIM-1)) begin
            phase_d[i_chan] = '0;
            state_d         = S_MAC;
            chan_d          = i_chan;
            rptr_d          = wptr_q[i_chan];  // slot just written holds the newest sample
            tap_d           = '0;
            acc_d           = '0;
          end else begin
            phase_d[i_chan] = phase_q[i_chan] + 1'b1;
          end
        end
      end
      S_MAC: begin
        if ({1'b0, tap_q} < fill_q[chan_q]) acc_d = acc_q + ACC_W'(prod);
        rptr_d = (rptr_q == '0) ? LGN_COEFFS'(NCOEFFS-1) : rptr_q - 1'b1;
        tap_d  = tap_q + 1'b1;
        if (tap_q == LGN_COEFFS'(NCOEFFS-1)) state_d = S_ROUND;
      end
      S_ROUND: begin
        state_d    = S_OUT;
        o_valid_d  = 1'b1;
        o_chan_d   = chan_q;
        o_sample_d = y_sat;
      end
      S_OUT: begin
        if (i_ready) begin
          state_d   = S_IDLE;
          o_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      for (int c = 0; c < NCHAN; c++) begin
        wptr_q[c]  <= '0;
        phase_q[c] <= '0;
        fill_q[c]  <= '0;
      end
      chan_q     <= '0;
      tap_q      <= '0;
      rptr_q     <= '0;
      acc_q      <= '0;
      o_valid_q  <= 1'b0;
      o_chan_q   <= '0;
      o_sample_q <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      phase_q    <= phase_d;
      fill_q     <= fill_d;
      chan_q     <= chan_d;
      tap_q      <= tap_d;
      rptr_q     <= rptr_d;
      acc_q      <= acc_d;
      o_valid_q  <= o_valid_d;
      o_chan_q   <= o_chan_d;
      o_sample_q <= o_sample_d;
    end
  end

  // NOTE: the sample and coefficient memories are deliberately not reset; fill masks stale history.
  always_ff @(posedge i_clk) begin
    if (dmem_we) dmem[i_chan][wptr_q[i_chan]] <= i_sample;
    if (cmem_we) cmem[i_caddr] <= i_cdata;
  end

  assign o_ready  = idle;
  assign o_cbusy  = !idle;
  assign o_valid  = o_valid_q;
  assign o_chan   = o_chan_q;
  assign o_sample = o_sample_q;

endmodule

// File: tb/tb_dsd_mc_decim.sv
// Randomized scoreboard bench for dsd_mc_decim against an arithmetic FIR model
// (sum over the newest samples of each channel, round half up, saturate).
module tb_dsd_mc_decim;
  localparam int AW    = 24;
  localparam int CW    = 16;
  localparam int NC    = 64;
  localparam int LGN   = 6;
  localparam int DECIM = 4;
  localparam int NCHAN = 3;
  localparam int LGCH  = 2;
  localparam int SH    = 15;
  localparam int LAT   = NC + 2;
  localparam longint MAXV = (longint'(1) <<< (AW-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (AW-1));

  logic                 i_clk = 1'b0, i_rst_n = 1'b0;
  logic                 i_cwr = 1'b0;
  logic [LGN-1:0]       i_caddr = '0;
  logic [CW-1:0]        i_cdata = '0;
  logic                 o_cbusy, o_ready, o_valid;
  logic                 i_valid = 1'b0, i_ready = 1'b1;
  logic [LGCH-1:0]      i_chan = '0, o_chan;
  logic signed [AW-1:0] i_sample = '0, o_sample;

  dsd_mc_decim #(.AUDIO_WIDTH(AW), .COEFF_W(CW), .NCOEFFS(NC), .DECIM(DECIM),
                 .NCHAN(NCHAN), .OUT_SHIFT(SH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cwr(i_cwr), .i_caddr(i_caddr),
    .i_cdata(i_cdata), .o_cbusy(o_cbusy), .i_valid(i_valid), .o_ready(o_ready),
    .i_chan(i_chan), .i_sample(i_sample), .o_valid(o_valid), .i_ready(i_ready),
    .o_chan(o_chan), .o_sample(o_sample));

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: coefficient array and newest-first history per channel.
  int cm [NC];
  int hist [NCHAN][NC];
  int cnt [NCHAN];
  int phase [NCHAN];

  typedef struct { int ch; longint val; int due; } exp_t;
  exp_t sb [$];

  function automatic longint model_out(input int ch);
    longint acc = 0;
    for (int k = 0; k < cnt[ch]; k++) acc += longint'(cm[k]) * longint'(hist[ch][k]);
    acc = (acc + (longint'(1) <<< (SH-1))) >>> SH;
    if (acc > MAXV) acc = MAXV;
    if (acc < MINV) acc = MINV;
    return acc;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NCHAN; c++) begin
      cnt[c] = 0;
      phase[c] = 0;
    end
    sb.delete();
  endtask

  task automatic wait_ready();
    int guard = 0;
    @(negedge i_clk);
    while (!o_ready) begin
      @(negedge i_clk);
      guard++;
      if (guard > 2000) begin
        $display("FAIL ready_timeout: o_ready stuck at 0 for %0d cycles", guard);
        $fatal(1, "bench aborted");
      end
    end
  endtask

  task automatic send(input int ch, input int smp, input bit cw = 1'b0,
                      input int ca = 0, input int cd = 0);
    int c;
    wait_ready();
    i_valid = 1'b1; i_chan = LGCH'(ch); i_sample = AW'(smp);
    i_cwr = cw; i_caddr = LGN'(ca); i_cdata = CW'(cd);
    c = cyc;
    @(posedge i_clk);
    #1 i_valid = 1'b0; i_cwr = 1'b0;
    if (cw) cm[ca] = int'($signed(CW'(cd)));
    if (ch < NCHAN) begin
      for (int k = NC-1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
      hist[ch][0] = smp;
      if (cnt[ch] < NC) cnt[ch]++;
      phase[ch]++;
      if (phase[ch] == DECIM) begin
        phase[ch] = 0;
        sb.push_back('{ch: ch, val: model_out(ch), due: c + LAT});
      end
    end
  endtask

  task automatic cwrite(input int a, input int d);
    bit busy;
    @(negedge i_clk);
    i_cwr = 1'b1; i_caddr = LGN'(a); i_cdata = CW'(d);
    busy = o_cbusy;
    @(posedge i_clk);
    #1 i_cwr = 1'b0;
    if (!busy) cm[a] = int'($signed(CW'(d)));
  endtask

  function automatic int rnd_sample();
    case ($urandom_range(0, 4))
      0: return int'($signed(AW'($urandom)));
      1: return int'($urandom_range(0, 10000)) - 5000;
      2: return int'(MAXV);
      3: return int'(MINV);
      default: return int'($urandom_range(0, 400)) - 200;
    endcase
  endfunction

  task automatic drain();
    int guard = 0;
    while ((sb.size() != 0 || o_valid || !o_ready) && guard < 1000) begin
      @(negedge i_clk);
      guard++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  // Output-side ready: random unless held low.
  bit bp_hold = 1'b0;
  initial forever begin
    @(posedge i_clk);
    #1 i_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard on each new output, then checks it holds steady.
  bit prev_valid = 1'b0;
  int hold_ch;
  longint hold_s;
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (o_valid) begin
        if (!prev_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("latency", cyc, e.due);
            check("o_chan", o_chan, e.ch);
            check("o_sample", $signed(o_sample), e.val);
          end
          hold_ch = o_chan;
          hold_s  = $signed(o_sample);
        end else begin
          check("hold_chan", o_chan, hold_ch);
          check("hold_sample", $signed(o_sample), hold_s);
        end
        check("ready_in_out", o_ready, 0);
        check("cbusy_in_out", o_cbusy, 1);
      end
      prev_valid = o_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "bench aborted");
  end

  initial begin
    int guard;
    model_clear();
    repeat (3) @(negedge i_clk);
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_cbusy", o_cbusy, 0);
    check("rst_chan", o_chan, 0);
    check("rst_sample", o_sample, 0);
    i_rst_n = 1'b1;

    // Random coefficients, then random interleaved traffic with invalid channel 3.
    for (int k = 0; k < NC; k++) cwrite(k, int'($urandom_range(0, 8192)) - 4096);
    for (int n = 0; n < 160; n++) begin
      if ($urandom_range(0, 7) == 0)
        send($urandom_range(0, 3), rnd_sample(), 1'b1, $urandom_range(0, NC-1),
             int'($urandom_range(0, 65535)));
      else
        send($urandom_range(0, 3), rnd_sample());
    end
    drain();

    // Full-scale DC drives the accumulator to both saturation rails.
    for (int k = 0; k < NC; k++) cwrite(k, 'h7FFF);
    for (int n = 0; n < NC + 8; n++) send(2, int'(MAXV));
    for (int n = 0; n < NC + 8; n++) send(2, int'(MINV));
    drain();

    // Backpressure: hold the output, attempt a coefficient write while busy.
    for (int k = 0; k < NC; k++) cwrite(k, int'($urandom_range(0, 2000)) - 1000);
    bp_hold = 1'b1;
    for (int n = 0; n < DECIM; n++) send(1, int'($urandom_range(0, 20000)) - 10000);
    guard = 0;
    while (!o_valid && guard < 200) begin @(negedge i_clk); guard++; end
    check("bp_valid_seen", o_valid, 1);
    repeat (20) begin
      @(negedge i_clk);
      check("bp_valid_held", o_valid, 1);
    end
    cwrite(0, 'h1234);
    check("bp_cbusy", o_cbusy, 1);
    bp_hold = 1'b0;
    guard = 0;
    do begin @(negedge i_clk); guard++; end while (!(o_valid && i_ready) && guard < 200);
    @(negedge i_clk);
    check("ready_after_handshake", o_ready, 1);
    check("valid_after_handshake", o_valid, 0);
    for (int n = 0; n < 2 * DECIM; n++) send(1, rnd_sample());
    drain();

    // Reset in the middle of a MAC pass: the pending output must never appear.
    for (int n = 0; n < DECIM; n++) send(0, rnd_sample());
    repeat (30) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1 check("rst_mid_valid", o_valid, 0);
    model_clear();
    repeat (3) @(negedge i_clk);
    check("rst_mid_ready", o_ready, 1);
    check("rst_mid_cbusy", o_cbusy, 0);
    i_rst_n = 1'b1;
    send(0, 1000);
    for (int n = 0; n < 2 * DECIM - 1; n++) send(0, 0);
    for (int n = 0; n < 3 * DECIM; n++) send($urandom_range(0, 2), rnd_sample());
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
